// File: rtl/sync_fifo_reader_if.sv
// Signal bundle between the FIFO read port, the reader and its downstream consumer.
// master = the reader; slave = the FIFO/consumer side that faces it.
interface sync_fifo_reader_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic             enable;
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_data;
  logic             fifo_rd;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] word_count;

  modport master (
    input  enable, fifo_empty, fifo_data, out_ready,
    output fifo_rd, out_data, out_valid, word_count
  );

  modport slave (
    output enable, fifo_empty, fifo_data, out_ready,
    input  fifo_rd, out_data, out_valid, word_count
  );
endinterface

// File: rtl/sync_fifo_reader.sv
// Drains a registered-read FIFO into a two-slot skid buffer and presents the words
// on a valid/ready stream at up to one word per clock, counting delivered words.
module sync_fifo_reader #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  sync_fifo_reader_if.master  bus
);

  logic [1:0]       r_occ;
  logic             r_inflight;
  logic             r_head;
  logic             r_tail;
  logic [CNT_W-1:0] r_word_count;

  logic             w_valid;
  logic             w_pop;
  logic             w_rd;
  logic [2:0]       w_level;
  logic [WIDTH-1:0] w_slot_data [2];

  assign w_valid = (r_occ != 2'd0);
  assign w_pop   = w_valid & bus.out_ready;

  // Occupancy after this cycle's capture and pop; a read may only be issued if the
  // word it returns next cycle is guaranteed a free slot.
  assign w_level = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_rd    = reset & bus.enable & ~bus.fifo_empty & (w_level <= 3'd1);

  assign bus.fifo_rd    = w_rd;
  assign bus.out_valid  = w_valid;
  assign bus.out_data   = w_slot_data[r_head];
  assign bus.word_count = r_word_count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_occ        <= 2'd0;
      r_inflight   <= 1'b0;
      r_head       <= 1'b0;
      r_tail       <= 1'b0;
      r_word_count <= '0;
    end else begin
      assert (w_level <= 3'd2);
      r_inflight <= w_rd;
      r_occ      <= w_level[1:0];
      if (r_inflight) begin
        r_tail <= ~r_tail;
      end
      if (w_pop) begin
        r_head       <= ~r_head;
        r_word_count <= r_word_count + CNT_W'(1);
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_slot
      logic [WIDTH-1:0] r_data;

      always_ff @(posedge clk) begin
        if (!reset) begin
          r_data <= '0;
        end else if (r_inflight && (r_tail == 1'(gi))) begin
          r_data <= bus.fifo_data;
        end
      end

      assign w_slot_data[gi] = r_data;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_reader.sv
// Directed bench for sync_fifo_reader against a small behavioural FIFO with registered read.
module tb_sync_fifo_reader;
  localparam int W  = 8;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sync_fifo_reader_if #(.WIDTH(W), .CNT_W(CW)) bus ();

  sync_fifo_reader #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Behavioural FIFO: pointer-based storage, data_out registered one cycle after rd.
  logic [W-1:0] mem [0:255];
  int           wr_ptr   = 0;
  int           rd_ptr   = 0;
  int           rd_count = 0;
  logic         flush_req;

  assign bus.fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (flush_req) begin
      rd_ptr <= wr_ptr;
    end else if (bus.fifo_rd && (rd_ptr != wr_ptr)) begin
      bus.fifo_data <= mem[rd_ptr];
      rd_ptr        <= rd_ptr + 1;
      rd_count      <= rd_count + 1;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [W-1:0] d);
    mem[wr_ptr] = d;
    wr_ptr++;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Reads must never be issued against an empty FIFO; also log each delivered word.
  always @(negedge clk) begin
    chk("rd_while_empty", {31'd0, bus.fifo_rd & bus.fifo_empty}, 32'd0);
    if (reset && bus.out_valid && bus.out_ready)
      $display("xfer data=%h count_before=%0d", bus.out_data, bus.word_count);
  end

  typedef struct {
    logic         rst_n;
    logic         en;
    logic         rdy;
    logic         chk_data;
    logic         exp_rd;
    logic         exp_valid;
    logic [W-1:0] exp_data;
    logic [CW-1:0] exp_cnt;
  } vec_t;

  function automatic vec_t mk(input logic rst_n, input logic en, input logic rdy,
                              input logic cd, input logic rd, input logic v,
                              input logic [W-1:0] d, input logic [CW-1:0] c);
    vec_t t;
    t.rst_n = rst_n; t.en = en; t.rdy = rdy; t.chk_data = cd;
    t.exp_rd = rd; t.exp_valid = v; t.exp_data = d; t.exp_cnt = c;
    return t;
  endfunction

  vec_t vt [15];

  initial begin
    int base;
    int got;
    logic seen;
    logic [W-1:0] first_word;

    // Reset + streaming of 0x11..0x18, one row per cycle.
    vt[0]  = mk(0, 1, 1, 1, 0, 0, 8'h00, 4'd0);
    vt[1]  = mk(0, 1, 1, 1, 0, 0, 8'h00, 4'd0);
    vt[2]  = mk(0, 1, 1, 1, 0, 0, 8'h00, 4'd0);
    vt[3]  = mk(1, 1, 1, 1, 1, 0, 8'h00, 4'd0);
    vt[4]  = mk(1, 1, 1, 1, 1, 0, 8'h00, 4'd0);
    vt[5]  = mk(1, 1, 1, 1, 1, 1, 8'h11, 4'd0);
    vt[6]  = mk(1, 1, 1, 1, 1, 1, 8'h12, 4'd1);
    vt[7]  = mk(1, 1, 1, 1, 1, 1, 8'h13, 4'd2);
    vt[8]  = mk(1, 1, 1, 1, 1, 1, 8'h14, 4'd3);
    vt[9]  = mk(1, 1, 1, 1, 1, 1, 8'h15, 4'd4);
    vt[10] = mk(1, 1, 1, 1, 1, 1, 8'h16, 4'd5);
    vt[11] = mk(1, 1, 1, 1, 0, 1, 8'h17, 4'd6);
    vt[12] = mk(1, 1, 1, 1, 0, 1, 8'h18, 4'd7);
    vt[13] = mk(1, 1, 1, 0, 0, 0, 8'h00, 4'd8);
    vt[14] = mk(1, 1, 1, 0, 0, 0, 8'h00, 4'd8);

    reset         = 1'b0;
    bus.enable    = 1'b1;
    bus.out_ready = 1'b1;
    flush_req     = 1'b0;
    for (int i = 0; i < 8; i++) push(8'h11 + 8'(i));
    @(posedge clk);
    next_cycle();

    for (int i = 0; i < 15; i++) begin
      reset         = vt[i].rst_n;
      bus.enable    = vt[i].en;
      bus.out_ready = vt[i].rdy;
      @(negedge clk);
      chk($sformatf("vec%0d_rd", i), {31'd0, bus.fifo_rd}, {31'd0, vt[i].exp_rd});
      chk($sformatf("vec%0d_valid", i), {31'd0, bus.out_valid}, {31'd0, vt[i].exp_valid});
      if (vt[i].chk_data)
        chk($sformatf("vec%0d_data", i), {24'd0, bus.out_data}, {24'd0, vt[i].exp_data});
      chk($sformatf("vec%0d_count", i), {28'd0, bus.word_count}, {28'd0, vt[i].exp_cnt});
      next_cycle();
    end
    chk("stream_reads", rd_count, 8);

    // Backpressure: 10 stalled cycles, then drain 0xA0..0xA5 back to back.
    bus.out_ready = 1'b0;
    base = rd_count;
    for (int i = 0; i < 6; i++) push(8'hA0 + 8'(i));
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        chk("stall_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("stall_hold", {24'd0, bus.out_data}, 32'h000000A0);
      end
      next_cycle();
    end
    chk("stall_reads", rd_count - base, 2);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("drain_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("drain_data", {24'd0, bus.out_data}, 32'h000000A0 + 32'(k));
      next_cycle();
    end
    @(negedge clk);
    chk("drain_empty", {31'd0, bus.out_valid}, 32'd0);
    chk("drain_count", {28'd0, bus.word_count}, 32'd14);
    chk("drain_reads", rd_count - base, 6);
    next_cycle();

    // Enable gating: one read issued, enable dropped afterwards.
    base = rd_count;
    for (int i = 0; i < 4; i++) push(8'hC0 + 8'(i));
    @(negedge clk);
    chk("gate_rd_first", {31'd0, bus.fifo_rd}, 32'd1);
    next_cycle();
    bus.enable = 1'b0;
    @(negedge clk);
    chk("gate_rd_off", {31'd0, bus.fifo_rd}, 32'd0);
    next_cycle();
    @(negedge clk);
    chk("gate_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("gate_data", {24'd0, bus.out_data}, 32'h000000C0);
    next_cycle();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("gate_no_rd", {31'd0, bus.fifo_rd}, 32'd0);
      chk("gate_idle", {31'd0, bus.out_valid}, 32'd0);
      next_cycle();
    end
    chk("gate_reads", rd_count - base, 1);
    chk("gate_fifo_left", wr_ptr - rd_ptr, 3);
    chk("gate_count", {28'd0, bus.word_count}, 32'd15);
    flush_req = 1'b1;
    next_cycle();
    flush_req  = 1'b0;
    bus.enable = 1'b1;

    // Counter wrap: 18 words through a 4-bit counter.
    reset = 1'b0;
    for (int i = 0; i < 18; i++) push(8'h30 + 8'(i));
    next_cycle();
    reset = 1'b1;
    @(negedge clk);
    chk("wrap_rst_count", {28'd0, bus.word_count}, 32'd0);
    next_cycle();
    got = 0;
    for (int k = 0; k < 60 && got < 18; k++) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) got++;
      next_cycle();
    end
    chk("wrap_words", got, 18);
    chk("wrap_count", {28'd0, bus.word_count}, 32'd2);

    // Reset while one word is buffered and another is in flight.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(8'hE0 + 8'(i));
    next_cycle();
    next_cycle();
    reset     = 1'b0;
    flush_req = 1'b1;
    @(negedge clk);
    chk("mid_pre_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("mid_pre_data", {24'd0, bus.out_data}, 32'h000000E0);
    chk("mid_rd_forced", {31'd0, bus.fifo_rd}, 32'd0);
    next_cycle();
    flush_req = 1'b0;
    @(negedge clk);
    chk("mid_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("mid_count", {28'd0, bus.word_count}, 32'd0);
    chk("mid_data", {24'd0, bus.out_data}, 32'd0);
    next_cycle();
    reset         = 1'b1;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("mid_no_stale", {31'd0, bus.out_valid}, 32'd0);
      next_cycle();
    end
    push(8'h5A);
    seen = 1'b0;
    first_word = '0;
    for (int k = 0; k < 8 && !seen; k++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        seen = 1'b1;
        first_word = bus.out_data;
      end
      next_cycle();
    end
    chk("mid_fresh_seen", {31'd0, seen}, 32'd1);
    chk("mid_fresh_data", {24'd0, first_word}, 32'h0000005A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
